// File: rtl/wb_stage.sv
// wb_stage: writeback stage that merges in-order pipeline results with
// buffered results from the multi-cycle mul/div unit.
// The pipeline always has priority. Mul/div results wait in a small FIFO
// and retire in writeback slots that have no pipeline write.
// Optional build macro WB_RETIRE_CNT_EN adds the retire_cnt and
// md_retire_cnt writeback counters.
module wb_stage #(
  parameter int MD_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  logic            pipe_reg_write,
  input  logic [4:0]      pipe_rd,
  input  logic            pipe_memtoreg,
  input  logic            pipe_link,
  input  logic [XLEN-1:0] pipe_pc,
  input  logic [XLEN-1:0] pipe_alu_result,
  input  logic [XLEN-1:0] pipe_mem_rdata,
  input  logic [2:0]      pipe_funct3,
  input  logic [1:0]      pipe_addr_lo,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_result,
  output logic            md_ready,
  input  logic [4:0]      chk_rd,
  output logic            chk_hit,
  output logic            reg_write,
  output logic [4:0]      rd_wb,
  output logic [XLEN-1:0] wd
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt,
  output logic [31:0]     md_retire_cnt
`endif
);

  // Index width of the FIFO; pointers carry one extra wrap bit.
  localparam int AW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;

  // ---------------------------------------------------------------------
  // Mul/div result FIFO storage and pointers
  // ---------------------------------------------------------------------
  logic [4:0]      mem_rd_q   [MD_DEPTH];
  logic [XLEN-1:0] mem_data_q [MD_DEPTH];

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_w;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  logic            md_push;
  logic            md_store;
  logic            md_pop;

  logic            pipe_wr;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] pipe_data;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;

  logic [MD_DEPTH-1:0] ent_hit;

  // Output registers
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_wb_q, rd_wb_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            md_src_q, md_src_d;

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign count_w    = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count_w == '0);
  assign fifo_full  = (count_w == (AW+1)'(MD_DEPTH));
  assign head_rd    = mem_rd_q[rd_idx];
  assign head_data  = mem_data_q[rd_idx];

  // Ready depends only on fullness; a same-cycle pop never frees a slot early.
  assign md_ready = !fifo_full;
  assign md_push  = md_valid && !fifo_full;
  // Results for x0 complete the handshake but are never stored.
  assign md_store = md_push && (md_rd != 5'd0);

  // ---------------------------------------------------------------------
  // Pipeline candidate and arbitration
  // ---------------------------------------------------------------------
  assign pipe_wr = pipe_valid && pipe_reg_write && (pipe_rd != 5'd0);
  // The FIFO head only retires when the pipeline leaves the slot empty.
  assign md_pop  = !fifo_empty && !pipe_wr;

  // Pending-destination lookup: an entry is live if its distance from the
  // read pointer is below the current occupancy.
  generate
    for (genvar gi = 0; gi < MD_DEPTH; gi++) begin : g_hit
      logic [AW-1:0] ent_off;
      logic          ent_live;
      assign ent_off     = AW'(gi) - rd_idx;
      assign ent_live    = ({1'b0, ent_off} < count_w);
      assign ent_hit[gi] = ent_live && (mem_rd_q[gi] == chk_rd);
    end
  endgenerate

  assign chk_hit = (chk_rd != 5'd0) && (|ent_hit);

  // Load extraction: pick byte/halfword lane and sign- or zero-extend.
  always_comb begin
    load_byte = pipe_mem_rdata[7:0];
    load_half = pipe_mem_rdata[15:0];
    load_data = pipe_mem_rdata;
    case (pipe_addr_lo)
      2'd0:    load_byte = pipe_mem_rdata[7:0];
      2'd1:    load_byte = pipe_mem_rdata[15:8];
      2'd2:    load_byte = pipe_mem_rdata[23:16];
      default: load_byte = pipe_mem_rdata[31:24];
    endcase
    load_half = pipe_addr_lo[1] ? pipe_mem_rdata[31:16] : pipe_mem_rdata[15:0];
    case (pipe_funct3)
      3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = pipe_mem_rdata;
    endcase
  end

  // Pipeline data select: link address beats load data beats ALU result.
  always_comb begin
    pipe_data = pipe_alu_result;
    if (pipe_link) begin
      pipe_data = pipe_pc + XLEN'(4);
    end else if (pipe_memtoreg) begin
      pipe_data = load_data;
    end
  end

  // Next writeback: pipeline first, then FIFO head; idle slots hold rd/wd.
  always_comb begin
    reg_write_d = 1'b0;
    rd_wb_d     = rd_wb_q;
    wd_d        = wd_q;
    md_src_d    = 1'b0;
    if (pipe_wr) begin
      reg_write_d = 1'b1;
      rd_wb_d     = pipe_rd;
      wd_d        = pipe_data;
    end else if (md_pop) begin
      reg_write_d = 1'b1;
      rd_wb_d     = head_rd;
      wd_d        = head_data;
      md_src_d    = 1'b1;
    end
  end

  // Next FIFO pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (md_store) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (md_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (md_store) begin
      mem_rd_q[wr_idx]   <= md_rd;
      mem_data_q[wr_idx] <= md_result;
    end
  end

  // FIFO pointer registers; reset discards every buffered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_wb_q     <= 5'd0;
      wd_q        <= '0;
      md_src_q    <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_wb_q     <= rd_wb_d;
      wd_q        <= wd_d;
      md_src_q    <= md_src_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rd_wb     = rd_wb_q;
  assign wd        = wd_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;
  logic [31:0] md_retire_cnt_q;

  // Count each cycle with an active write; FIFO-sourced writes counted apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q    <= 64'd0;
      md_retire_cnt_q <= 32'd0;
    end else begin
      if (reg_write_q) begin
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
      if (reg_write_q && md_src_q) begin
        md_retire_cnt_q <= md_retire_cnt_q + 32'd1;
      end
    end
  end

  assign retire_cnt    = retire_cnt_q;
  assign md_retire_cnt = md_retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the writeback behaviour.
module tb_wb_stage;
  localparam int XLEN = 32;
  localparam int D    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_valid, pipe_reg_write, pipe_memtoreg, pipe_link;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_pc, pipe_alu_result, pipe_mem_rdata;
  logic [2:0]      pipe_funct3;
  logic [1:0]      pipe_addr_lo;
  logic            md_valid;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_result;
  logic            md_ready;
  logic [4:0]      chk_rd;
  logic            chk_hit;
  logic            reg_write;
  logic [4:0]      rd_wb;
  logic [XLEN-1:0] wd;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]     retire_cnt;
  logic [31:0]     md_retire_cnt;
`endif

  wb_stage #(.MD_DEPTH(D), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd),
    .pipe_memtoreg(pipe_memtoreg), .pipe_link(pipe_link), .pipe_pc(pipe_pc),
    .pipe_alu_result(pipe_alu_result), .pipe_mem_rdata(pipe_mem_rdata),
    .pipe_funct3(pipe_funct3), .pipe_addr_lo(pipe_addr_lo),
    .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_ready(md_ready),
    .chk_rd(chk_rd), .chk_hit(chk_hit),
    .reg_write(reg_write), .rd_wb(rd_wb), .wd(wd)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt), .md_retire_cnt(md_retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference model state
  logic [4:0]  q_rd[$];
  logic [31:0] q_d[$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] exp_wd = 32'd0;
  logic        exp_md = 1'b0;
  longint unsigned exp_cnt = 0;
  longint unsigned exp_mdcnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_ref(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * a)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    pipe_valid = 0; pipe_reg_write = 0; pipe_rd = 0; pipe_memtoreg = 0;
    pipe_link = 0; pipe_pc = 0; pipe_alu_result = 0; pipe_mem_rdata = 0;
    pipe_funct3 = 0; pipe_addr_lo = 0; md_valid = 0; md_rd = 0; md_result = 0;
    chk_rd = 0;
  endtask

  task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] v);
    pipe_valid = 1; pipe_reg_write = 1; pipe_rd = rd; pipe_alu_result = v;
    pipe_memtoreg = 0; pipe_link = 0;
  endtask

  // One clock: inputs are already applied (after negedge). Checks the
  // combinational outputs, advances the model, checks registered outputs.
  task automatic cyc();
    logic pw;
    logic hit;
    bit   full;
    #1;
    hit = 1'b0;
    foreach (q_rd[i]) if (chk_rd != 0 && q_rd[i] == chk_rd) hit = 1'b1;
    check("md_ready", md_ready, q_rd.size() < D);
    check("chk_hit", chk_hit, hit);
    if (rst) begin
      q_rd.delete(); q_d.delete();
      exp_we = 0; exp_rd = 0; exp_wd = 0; exp_md = 0;
      exp_cnt = 0; exp_mdcnt = 0;
    end else begin
      exp_cnt   = exp_cnt + exp_we;
      exp_mdcnt = (exp_mdcnt + (exp_we && exp_md)) & 64'hFFFF_FFFF;
      pw   = pipe_valid && pipe_reg_write && pipe_rd != 0;
      full = (q_rd.size() == D);
      exp_md = 0;
      if (pw) begin
        exp_we = 1; exp_rd = pipe_rd;
        exp_wd = pipe_link ? pipe_pc + 32'd4 :
                 pipe_memtoreg ? ld_ref(pipe_mem_rdata, pipe_funct3, pipe_addr_lo) :
                 pipe_alu_result;
      end else if (q_rd.size() > 0) begin
        exp_we = 1; exp_md = 1;
        exp_rd = q_rd.pop_front();
        exp_wd = q_d.pop_front();
      end else begin
        exp_we = 0;
      end
      if (md_valid && !full && md_rd != 0) begin
        q_rd.push_back(md_rd);
        q_d.push_back(md_result);
      end
    end
    @(posedge clk);
    #1;
    check("reg_write", reg_write, exp_we);
    check("rd_wb", rd_wb, exp_rd);
    check("wd", wd, exp_wd);
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, exp_cnt);
    check("md_retire_cnt", md_retire_cnt, exp_mdcnt);
`endif
    txn++;
    $display("txn %0d rst=%0b we=%0b rd=%0d wd=%08h ready=%0b", txn, rst, reg_write,
             rd_wb, wd, md_ready);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0]  lf3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  lad [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] lex [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", reg_write, 0);
    check("rst_rd", rd_wb, 0);
    check("rst_wd", wd, 0);
    check("rst_ready", md_ready, 1);
    check("rst_hit", chk_hit, 0);
    rst = 0;

    // ALU write then idle
    pipe_alu(5'd5, 32'h12345678);
    cyc();
    check("alu_wd", wd, 32'h12345678);
    check("alu_rd", rd_wb, 5);
    idle_inputs();
    cyc();
    check("idle_we", reg_write, 0);

    // Load extraction table
    for (int i = 0; i < 5; i++) begin
      pipe_valid = 1; pipe_reg_write = 1; pipe_rd = 5'd9; pipe_memtoreg = 1;
      pipe_mem_rdata = 32'h80FF7F01; pipe_funct3 = lf3[i]; pipe_addr_lo = lad[i];
      cyc();
      check("load", wd, lex[i]);
    end

    // Link address, then x0 destination
    idle_inputs();
    pipe_valid = 1; pipe_reg_write = 1; pipe_rd = 5'd1; pipe_link = 1;
    pipe_pc = 32'h100; pipe_memtoreg = 1; pipe_alu_result = 32'hDEAD;
    cyc();
    check("link", wd, 32'h104);
    idle_inputs();
    pipe_valid = 1; pipe_reg_write = 1; pipe_rd = 5'd0; pipe_alu_result = 32'h55;
    cyc();
    check("x0_we", reg_write, 0);

    // Arbitration: pipe busy while two mul/div results arrive
    idle_inputs();
    pipe_alu(5'd3, 32'h1);
    md_valid = 1; md_rd = 5'd7; md_result = 32'hAAAA0000;
    cyc();
    pipe_alu(5'd4, 32'h2);
    md_rd = 5'd8; md_result = 32'hBBBB0000;
    cyc();
    md_valid = 0;
    check("full_ready", md_ready, 0);
    chk_rd = 5'd8;
    #1;
    check("hit8", chk_hit, 1);
    pipe_alu(5'd6, 32'h3);
    cyc();
    check("busy_rd", rd_wb, 6);
    idle_inputs();
    cyc();
    check("pop7_rd", rd_wb, 7);
    check("pop7_wd", wd, 32'hAAAA0000);
    check("ready_back", md_ready, 1);
    cyc();
    check("pop8_rd", rd_wb, 8);
    check("pop8_wd", wd, 32'hBBBB0000);

    // Reset with two buffered entries
    pipe_alu(5'd2, 32'h9);
    md_valid = 1; md_rd = 5'd10; md_result = 32'h1111;
    cyc();
    md_rd = 5'd11; md_result = 32'h2222;
    cyc();
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk_rd = 5'd10;
      cyc();
      check("post_rst_we", reg_write, 0);
    end

`ifdef WB_RETIRE_CNT_EN
    // Counters: 3 pipe writes + 2 mul/div retires
    rst = 1; cyc(); rst = 0;
    pipe_alu(5'd1, 32'h1); md_valid = 1; md_rd = 5'd12; md_result = 32'h12;
    cyc();
    pipe_alu(5'd2, 32'h2); md_rd = 5'd13; md_result = 32'h13;
    cyc();
    md_valid = 0;
    pipe_alu(5'd3, 32'h3);
    cyc();
    idle_inputs();
    repeat (3) cyc();
    check("cnt5", retire_cnt, 5);
    check("mdcnt2", md_retire_cnt, 2);
    rst = 1; cyc(); rst = 0;
    check("cnt_rst", retire_cnt, 0);
    check("mdcnt_rst", md_retire_cnt, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      pipe_valid     = ($urandom_range(0, 99) < 50);
      pipe_reg_write = ($urandom_range(0, 99) < 80);
      pipe_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_link      = ($urandom_range(0, 99) < 15);
      pipe_memtoreg  = ($urandom_range(0, 99) < 35);
      pipe_pc        = $urandom;
      pipe_alu_result = $urandom;
      pipe_mem_rdata = $urandom;
      pipe_funct3    = 3'($urandom_range(0, 7));
      pipe_addr_lo   = 2'($urandom_range(0, 3));
      md_valid       = ($urandom_range(0, 99) < 40);
      md_rd          = 5'($urandom_range(0, 9));
      md_result      = $urandom;
      chk_rd         = 5'($urandom_range(0, 9));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage. Drives the register-file write port (reg_write, rd_wb, wd) that the decode stage consumes.
- Merges two result sources:
  - the in-order pipeline result (ALU, load data, or JAL/JALR link address);
  - results from the multi-cycle M-extension mul/div unit.
- Mul/div results are buffered in a small FIFO and retired in idle writeback slots.

Parameters:
- MD_DEPTH, 2, mul/div result FIFO entries. Power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pipe_valid  in  1  pipeline writeback candidate present this cycle.
- pipe_reg_write  in  1  candidate writes a register.
- pipe_rd  in  5  destination register.
- pipe_memtoreg  in  1  select load data.
- pipe_link  in  1  select pc+4 (JAL/JALR).
- pipe_pc  in  XLEN  instruction PC.
- pipe_alu_result  in  XLEN  ALU result.
- pipe_mem_rdata  in  XLEN  raw aligned memory word.
- pipe_funct3  in  3  load size/sign.
- pipe_addr_lo  in  2  low bits of load address.
- md_valid  in  1  mul/div result offered.
- md_rd  in  5  mul/div destination.
- md_result  in  XLEN  mul/div result.
- md_ready  out  1  FIFO can accept (= !full).
- chk_rd  in  5  register queried by hazard unit.
- chk_hit  out  1  chk_rd != 0 and it matches the rd of any valid FIFO entry.
- reg_write  out  1  register-file write enable.
- rd_wb  out  5  write address.
- wd  out  XLEN  write data.

Behaviour:
- Reset: reg_write=0, rd_wb=0, wd=0, FIFO empty (md_ready=1, chk_hit=0). Reset mid-operation discards all buffered mul/div results.
- Outputs are registered; 1-cycle latency from pipe_* to reg_write/rd_wb/wd.
- Pipe write condition: pipe_valid && pipe_reg_write && pipe_rd != 0.
- Pipe data select, in priority order: pipe_link -> pipe_pc+4 (mod 2^XLEN); pipe_memtoreg -> load extract; else pipe_alu_result.
- Load extract by pipe_funct3:
  - 000 LB: sign-extended byte at pipe_addr_lo.
  - 100 LBU: zero-extended byte at pipe_addr_lo.
  - 001 LH: sign-extended halfword selected by pipe_addr_lo[1]; pipe_addr_lo[0] ignored.
  - 101 LHU: zero-extended halfword, same selection.
  - 010 and all other codes: full word.
- FIFO push: md_valid && md_ready. Entries with md_rd == 0 are accepted and dropped, never written.
- md_ready is !full only. Push is refused when full even if a pop occurs in the same cycle.
- FIFO pop: head valid && no pipe write this cycle. The head is driven to reg_write/rd_wb/wd next cycle.
- Arbitration: the pipeline always wins. Mul/div results retire only in slots with no pipe write. Minimum mul/div latency is 2 cycles (push, then pop).
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged; order preserved (FIFO).
- Idle slot (no pipe write, FIFO empty): reg_write=0; rd_wb and wd hold their previous values.
- chk_hit is combinational over valid entries. The hazard unit stalls any pipe instruction reading or writing a pending rd. This preserves RAW and WAW ordering, so the block performs no reordering checks.
- Pointer wrap: read/write pointers are log2(MD_DEPTH) bits plus one extra bit for full/empty disambiguation.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds outputs retire_cnt (64-bit) and md_retire_cnt (32-bit), reset to 0.
  - retire_cnt increments by 1 on every cycle in which reg_write is asserted.
  - md_retire_cnt increments only for writes sourced from the FIFO.
  - Both counters wrap silently.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ALU write: rst 2 cycles; pipe rd=5, alu=0x12345678 -> next cycle reg_write=1, rd_wb=5, wd=0x12345678. A following idle cycle gives reg_write=0.
- Load extract: mem_rdata=0x80FF7F01, memtoreg=1 ->
  - LB, addr_lo=3 -> wd=0xFFFFFF80;
  - LBU, addr_lo=1 -> wd=0x0000007F;
  - LH, addr_lo=2 -> wd=0xFFFF80FF;
  - LHU, addr_lo=0 -> wd=0x00007F01;
  - LW -> wd=0x80FF7F01.
- Link and x0: pipe_link=1, pc=0x00000100, rd=1 -> wd=0x00000104. Pipe rd=0 with reg_write=1 -> reg_write stays 0.
- Arbitration/FIFO: md push rd=7 (0xAAAA0000) and rd=8 (0xBBBB0000) while the pipe writes every cycle ->
  - md_ready=0 after 2 pushes;
  - chk_rd=8 -> chk_hit=1;
  - on the first idle pipe slot, x7 retires, then x8 on the next idle slot, in order;
  - md_ready returns to 1 after the first pop.
- Reset mid-operation: FIFO holding 2 entries, assert rst 1 cycle -> no mul/div writes ever appear; md_ready=1, chk_hit=0.
- WB_RETIRE_CNT_EN build: 3 pipe writes + 2 mul/div retires -> retire_cnt=5, md_retire_cnt=2. A reset returns both counters to 0.
